// File: rtl/receiver_fsm_pkg.sv
// Shared types and defaults for the receive side of the four-phase
// push synchroniser.
package receiver_fsm_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_WIDTH_DEF   = 8;

  // Two-bit receiver state; 10 and 11 are never entered and recover to IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACKED    = 2'b01,
    UNUSED_2 = 2'b10,
    UNUSED_3 = 2'b11
  } rx_state_t;

  // A new word may be captured when the request is seen and the holding
  // register is empty or is being drained on the same edge.
  function automatic logic can_capture(input logic rs, input logic dv, input logic take);
    return rs & (~dv | take);
  endfunction

endpackage

// File: rtl/receiver_fsm_if.sv
// Transmitter-facing req/data/ack bus plus the consumer valid/ready side.
// master: transmitter and consumer (the bench); slave: the receiver.
interface receiver_fsm_if
  import receiver_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  req;
  logic [DATA_WIDTH-1:0] input_rx;
  logic                  ack;
  logic [DATA_WIDTH-1:0] output_rx;
  logic                  dv;
  logic                  rdy;

  modport master (output req, input_rx, rdy, input ack, output_rx, dv);
  modport slave  (input req, input_rx, rdy, output ack, output_rx, dv);
endinterface

// File: rtl/receiver_fsm_rx_sync.sv
// SYNC_STAGES-deep flop chain bringing an asynchronous level into clk.
// Reusable for the transmitter's ack path.
module receiver_fsm_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_reg;

  // Shift the incoming level one stage per clock; all stages clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
  end

  assign q = sync_reg[SYNC_STAGES-1];
endmodule

// File: rtl/receiver_fsm.sv
// Receive FSM: synchronises req, captures the data bus into a one-entry
// holding register, returns ack, and withholds ack while the register is full.
module receiver_fsm
  import receiver_fsm_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  receiver_fsm_if.slave        bus,
  output logic                 f,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);
  logic                  rs;
  logic                  rs_d_reg;
  logic                  f_reg;
  rx_state_t             state_reg, state_next;
  logic                  ack_reg, ack_next;
  logic                  dv_reg, dv_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  take;

  receiver_fsm_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.req),
    .q     (rs)
  );

  // Registered one-cycle pulse on each synchronised rising edge of req.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_d_reg <= 1'b0;
      f_reg    <= 1'b0;
    end else begin
      rs_d_reg <= rs;
      f_reg    <= rs & ~rs_d_reg;
    end
  end

  // FSM state, ack, holding register and transfer counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      dv_reg    <= 1'b0;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      dv_reg    <= dv_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; a consumer take clears dv unless a capture lands on the same edge.
  always_comb begin
    take       = dv_reg & bus.rdy;
    state_next = state_reg;
    ack_next   = ack_reg;
    dv_next    = dv_reg & ~take;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        ack_next = 1'b0;
        if (can_capture(rs, dv_reg, take)) begin
          data_next  = bus.input_rx;
          dv_next    = 1'b1;
          ack_next   = 1'b1;
          state_next = ACKED;
        end
      end
      ACKED: begin
        // Held until req falls, so a long req never re-captures.
        ack_next = 1'b1;
        if (!rs) begin
          ack_next   = 1'b0;
          cnt_next   = cnt_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ack       = ack_reg;
  assign bus.dv        = dv_reg;
  assign bus.output_rx = data_reg;
  assign f             = f_reg;
  assign xfer_cnt      = cnt_reg;
endmodule

// File: tb/tb_receiver_fsm.sv
// Bench for receiver_fsm: directed latency/backpressure/reset cases, a
// randomized transmitter+consumer run against a queue model, and a wrap run.
module tb_receiver_fsm;
  logic       clk;
  logic       reset;
  logic       f;
  logic [7:0] xfer_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         f_total  = 0;

  receiver_fsm_if #(.DATA_WIDTH(8)) bus ();

  receiver_fsm #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .f        (f),
    .xfer_cnt (xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (f === 1'b1) f_total <= f_total + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four-phase handshake as the transmitter would drive it.
  task automatic send(input logic [7:0] data, output int rise_lat, output int fall_lat);
    int n;
    bus.req = 1'b1;
    bus.input_rx = data;
    n = 0;
    do begin tick(); n++; end while (bus.ack !== 1'b1 && n < 100);
    rise_lat = n;
    check("send_ack_rise", bus.ack, 1'b1);
    check("send_cap_data", bus.output_rx, data);
    bus.req = 1'b0;
    bus.input_rx = 8'($urandom);
    n = 0;
    do begin tick(); n++; end while (bus.ack !== 1'b0 && n < 100);
    fall_lat = n;
    check("send_ack_fall", bus.ack, 1'b0);
  endtask

  initial begin
    int rl, fl, f0, acklow, dvfall, hs, phase, gap, wcnt, cyc;
    logic prev_dv, lat_chk, tx_en;
    logic [7:0] cur;
    logic [7:0] exp_q[$];

    reset = 1'b0;
    bus.req = 1'b0;
    bus.rdy = 1'b0;
    bus.input_rx = 8'h00;
    tick(); tick();
    check("rst_ack", bus.ack, 0);
    check("rst_dv", bus.dv, 0);
    check("rst_out", bus.output_rx, 0);
    check("rst_f", f, 0);
    check("rst_cnt", xfer_cnt, 0);
    reset = 1'b1;

    // Single transfer with exact latency
    f0 = f_total;
    bus.rdy = 1'b1; bus.input_rx = 8'hA5; bus.req = 1'b1;
    tick(); tick();
    check("t1_ack_e1", bus.ack, 0);
    tick();
    check("t1_ack_e2", bus.ack, 1);
    check("t1_dv_e2", bus.dv, 1);
    check("t1_out_e2", bus.output_rx, 8'hA5);
    check("t1_f_e2", f, 1);
    tick();
    check("t1_f_e3", f, 0);
    check("t1_dv_drained", bus.dv, 0);
    check("t1_ack_held", bus.ack, 1);
    bus.req = 1'b0;
    tick(); tick();
    check("t1_ack_fall_e1", bus.ack, 1);
    tick();
    check("t1_ack_fall_e2", bus.ack, 0);
    check("t1_cnt", xfer_cnt, 1);
    check("t1_f_count", f_total - f0, 1);
    $display("single transfer: data %02h cnt %0d", bus.output_rx, xfer_cnt);

    // Backpressure: a full holding register blocks ack
    bus.rdy = 1'b0;
    send(8'h11, rl, fl);
    check("t2_rise_lat", rl, 3);
    check("t2_fall_lat", fl, 3);
    bus.req = 1'b1; bus.input_rx = 8'h22;
    repeat (6) tick();
    check("t2_bp_ack", bus.ack, 0);
    check("t2_bp_out", bus.output_rx, 8'h11);
    check("t2_bp_dv", bus.dv, 1);
    bus.rdy = 1'b1;
    tick();
    check("t2_swap_out", bus.output_rx, 8'h22);
    check("t2_swap_dv", bus.dv, 1);
    check("t2_swap_ack", bus.ack, 1);
    bus.rdy = 1'b0; bus.req = 1'b0;
    repeat (3) tick();
    check("t2_ack_fall", bus.ack, 0);
    check("t2_cnt", xfer_cnt, 3);
    $display("backpressure: out %02h cnt %0d", bus.output_rx, xfer_cnt);

    // Drain with req low
    bus.rdy = 1'b1;
    tick();
    check("t3_dv", bus.dv, 0);
    check("t3_out", bus.output_rx, 8'h22);
    check("t3_ack", bus.ack, 0);
    bus.rdy = 1'b0;
    $display("drain: dv %0d out %02h", bus.dv, bus.output_rx);

    // Held req: one capture only
    f0 = f_total;
    bus.req = 1'b1; bus.input_rx = 8'h5A;
    repeat (3) tick();
    check("t4_ack", bus.ack, 1);
    check("t4_out", bus.output_rx, 8'h5A);
    acklow = 0; dvfall = 0; prev_dv = bus.dv;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) bus.rdy = 1'b1;
      bus.input_rx = 8'($urandom);
      tick();
      if (bus.ack !== 1'b1) acklow++;
      if (prev_dv && !bus.dv) dvfall++;
      prev_dv = bus.dv;
    end
    check("t4_ack_low_cycles", acklow, 0);
    check("t4_dv_falls", dvfall, 1);
    check("t4_dv_end", bus.dv, 0);
    check("t4_f_count", f_total - f0, 1);
    bus.req = 1'b0; bus.rdy = 1'b0;
    repeat (3) tick();
    check("t4_ack_fall", bus.ack, 0);
    $display("held req: captures %0d dv falls %0d", f_total - f0, dvfall);

    // Reset mid-handshake, req still high afterwards
    bus.req = 1'b1; bus.input_rx = 8'h77;
    repeat (3) tick();
    check("t5_ack_pre", bus.ack, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_ack", bus.ack, 0);
    check("t5_rst_dv", bus.dv, 0);
    check("t5_rst_out", bus.output_rx, 0);
    check("t5_rst_cnt", xfer_cnt, 0);
    tick();
    reset = 1'b1;
    tick(); tick();
    check("t5_recap_early", bus.ack, 0);
    tick();
    check("t5_recap_ack", bus.ack, 1);
    check("t5_recap_out", bus.output_rx, 8'h77);
    bus.req = 1'b0;
    repeat (3) tick();
    check("t5_cnt", xfer_cnt, 1);
    bus.rdy = 1'b1; tick(); bus.rdy = 1'b0;
    $display("reset mid-handshake: recaptured %02h", 8'h77);

    // Randomized transmitter and consumer against a queue model
    reset = 1'b0; tick(); reset = 1'b1; tick();
    f0 = f_total; hs = 0; phase = 0; gap = 2; wcnt = 0; cur = 8'h00; lat_chk = 1'b0;
    exp_q.delete();
    cyc = 0;
    while (cyc < 8000) begin
      tx_en = (cyc < 4000);
      if (!tx_en && phase == 0 && exp_q.size() == 0 && bus.dv === 1'b0) break;
      // Transmitter observes ack
      if (phase == 1) begin
        wcnt++;
        if (bus.ack === 1'b1) begin
          check("rand_cap_data", bus.output_rx, cur);
          if (lat_chk) check("rand_ack_lat", wcnt, 3);
          exp_q.push_back(cur);
          bus.req = 1'b0; bus.input_rx = 8'($urandom);
          wcnt = 0; phase = 2;
        end else if (wcnt > 400) begin
          check("rand_ack_rise_timeout", bus.ack, 1);
          break;
        end
      end else if (phase == 2) begin
        wcnt++;
        if (bus.ack === 1'b0) begin
          check("rand_release_lat", wcnt, 3);
          hs++;
          check("rand_xfer_cnt", xfer_cnt, hs % 256);
          $display("handshake %0d data %02h", hs, cur);
          phase = 0; gap = $urandom_range(0, 4);
        end else if (wcnt > 50) begin
          check("rand_ack_fall_timeout", bus.ack, 0);
          break;
        end
      end
      // Consumer: holding register is full exactly when a captured word is untaken
      check("rand_dv", bus.dv, exp_q.size() != 0);
      bus.rdy = tx_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.dv === 1'b1 && bus.rdy) begin
        if (exp_q.size() == 0) check("rand_take_unexpected", bus.dv, 0);
        else check("rand_take_data", bus.output_rx, exp_q.pop_front());
      end
      // Transmitter raises the next request
      if (phase == 0 && tx_en) begin
        if (gap == 0) begin
          cur = 8'($urandom);
          bus.req = 1'b1; bus.input_rx = cur;
          lat_chk = (exp_q.size() == 0);
          wcnt = 0; phase = 1;
        end else begin
          gap--;
          bus.input_rx = 8'($urandom);
        end
      end
      tick();
      cyc++;
    end
    check("rand_end_dv", bus.dv, 0);
    check("rand_end_queue", exp_q.size(), 0);
    check("rand_f_count", f_total - f0, hs);
    check("rand_end_cnt", xfer_cnt, hs % 256);
    bus.rdy = 1'b0; bus.req = 1'b0;

    // Counter wrap: 256 in-order words
    reset = 1'b0; tick(); reset = 1'b1; tick();
    bus.rdy = 1'b1;
    f0 = f_total;
    for (int i = 0; i < 256; i++) begin
      send(8'(i), rl, fl);
      check("wrap_rise_lat", rl, 3);
      if (i == 254) check("wrap_cnt_255", xfer_cnt, 255);
      $display("wrap handshake %0d data %02h", i, i);
    end
    tick();
    check("wrap_cnt_zero", xfer_cnt, 0);
    check("wrap_f_count", f_total - f0, 256);
    check("wrap_dv_end", bus.dv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
